// File: rtl/spi_rx_pkg.sv
// spi_rx_pkg
//   Shared definitions for the FTDI-to-OLED SPI responder (spi_oled_rx) and
//   its optional output FIFO (spi_rx_fifo).
//   - BYTE_W / ENTRY_W : byte width and stream entry width ({dc, data[7:0]})
//   - state_e          : receiver FSM encodings (ST_IDLE, ST_SHIFT)
//   - fsm_t            : complete FSM register (state, bit counter, shifter),
//                        kept as one struct so checkers can bind to it
//   - make_entry       : packs a D/C flag and a byte into a stream entry
package spi_rx_pkg;

  localparam int BYTE_W  = 8;
  localparam int ENTRY_W = 9;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  typedef struct packed {
    state_e              state;
    logic [2:0]          bit_cnt;
    logic [BYTE_W-1:0]   shreg;
  } fsm_t;

  function automatic logic [ENTRY_W-1:0] make_entry(input logic dc,
                                                    input logic [BYTE_W-1:0] data);
    return {dc, data};
  endfunction

endpackage

// File: rtl/spi_rx_fifo.sv
// spi_rx_fifo
//   Synchronous FIFO holding received {dc, data} entries for spi_oled_rx.
//   The head entry is read combinationally from registered storage.
//   A push while full is accepted only when a pop happens in the same cycle
//   (the pop frees the slot the push then fills); otherwise it is ignored and
//   the caller is expected to flag the drop. A pop while empty is ignored.
//   Ports:
//     clk, reset   : clock, synchronous active-high reset
//     push, entry  : write request and data
//     pop          : remove head entry
//     head         : current head entry
//     full, empty  : occupancy status
module spi_rx_fifo
  import spi_rx_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic [ENTRY_W-1:0] entry,
  input  logic               pop,
  output logic [ENTRY_W-1:0] head,
  output logic               full,
  output logic               empty
);

  localparam int AW = $clog2(DEPTH);

  logic [ENTRY_W-1:0] mem [DEPTH];
  // One extra pointer bit distinguishes full from empty.
  logic [AW:0]        wr_ptr;
  logic [AW:0]        rd_ptr;
  logic               do_push;
  logic               do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= entry;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_oled_rx.sv
// spi_oled_rx
//   SPI responder that snoops the FTDI MPSSE link driving the PmodOLEDrgb.
//   SCLK, MOSI, CS_n and D/C are oversampled on clk, bytes are shifted in
//   MSB-first on synchronized SCLK rising edges (modes 0 and 3), tagged with
//   the D/C level seen on the 8th edge and offered on a valid/ready stream.
//
//   Build option: define SPI_RX_FIFO_EN to replace the single output register
//   with a FIFO_DEPTH-entry FIFO (spi_rx_fifo).
//
//   Ports:
//     clk, reset           : system clock, synchronous active-high reset
//     spi_sclk/mosi/cs_n/dc: asynchronous FTDI pins
//     rx_data, rx_dc       : received byte and its D/C tag
//     rx_valid, rx_ready   : output stream handshake
//     busy                 : synchronized chip select active
//     overflow             : sticky, a byte was dropped on a full stage
//     frame_err            : sticky, CS deasserted mid-byte
//
//   Handshake: a beat transfers on every clk edge where rx_valid && rx_ready.
//   While rx_valid is high and rx_ready low, rx_data/rx_dc/rx_valid hold.
//   rx_valid never depends combinationally on rx_ready.
module spi_oled_rx
  import spi_rx_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              spi_sclk,
  input  logic              spi_mosi,
  input  logic              spi_cs_n,
  input  logic              spi_dc,
  output logic [BYTE_W-1:0] rx_data,
  output logic              rx_dc,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              busy,
  output logic              overflow,
  output logic              frame_err
);

  // ---------------------------------------------------------------------------
  // Input synchronizers and SCLK edge detector
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] dc_sync;
  // Fills with ones after reset; its top bit marks the point where cs_sync
  // holds real pad samples rather than reset values.
  logic [SYNC_STAGES-1:0] flush_pipe;
  logic                   sclk_d;
  logic                   armed;

  logic sclk_s;
  logic mosi_s;
  logic cs_s;
  logic dc_s;
  logic rise_edge;

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign dc_s      = dc_sync[SYNC_STAGES-1];
  assign rise_edge = sclk_s & ~sclk_d;
  assign busy      = ~cs_s;

  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_sync  <= '0;
      mosi_sync  <= '0;
      cs_sync    <= '1;
      dc_sync    <= '0;
      flush_pipe <= '0;
      sclk_d     <= 1'b0;
      armed      <= 1'b0;
    end else begin
      sclk_sync  <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      mosi_sync  <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      cs_sync    <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      dc_sync    <= {dc_sync[SYNC_STAGES-2:0], spi_dc};
      flush_pipe <= {flush_pipe[SYNC_STAGES-2:0], 1'b1};
      sclk_d     <= sclk_s;
      // A transfer already in flight when reset lifts must not be captured:
      // only a CS high level seen on real samples arms the receiver.
      if (flush_pipe[SYNC_STAGES-1] && cs_s) begin
        armed <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Receiver FSM and shifter
  // ---------------------------------------------------------------------------
  fsm_t               fsm_q;
  fsm_t               fsm_d;
  logic               push;
  logic               frame_err_set;
  logic [BYTE_W-1:0]  shifted;
  logic [ENTRY_W-1:0] push_entry;

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q <= '0;
    end else begin
      fsm_q <= fsm_d;
    end
  end

  always_comb begin
    fsm_d         = fsm_q;
    push          = 1'b0;
    frame_err_set = 1'b0;
    shifted       = {fsm_q.shreg[BYTE_W-2:0], mosi_s};
    push_entry    = make_entry(dc_s, shifted);

    case (fsm_q.state)
      ST_IDLE: begin
        fsm_d.bit_cnt = '0;
        // Entering on the CS level (not on SCLK) means an SCLK that is
        // already high at CS fall (mode 3) is not counted as an edge.
        if (armed && !cs_s) begin
          fsm_d.state = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (cs_s) begin
          if (fsm_q.bit_cnt != 3'd0) begin
            frame_err_set = 1'b1;
          end
          fsm_d.state   = ST_IDLE;
          fsm_d.bit_cnt = '0;
        end else if (rise_edge) begin
          fsm_d.shreg = shifted;
          if (fsm_q.bit_cnt == 3'd7) begin
            push          = 1'b1;
            fsm_d.bit_cnt = '0;
          end else begin
            fsm_d.bit_cnt = fsm_q.bit_cnt + 3'd1;
          end
        end
      end
      default: begin
        fsm_d.state   = ST_IDLE;
        fsm_d.bit_cnt = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output stage
  // ---------------------------------------------------------------------------
  logic pop;
  logic overflow_set;
  logic overflow_q;
  logic frame_err_q;

  assign pop = rx_valid & rx_ready;

`ifdef SPI_RX_FIFO_EN
  logic [ENTRY_W-1:0] fifo_head;
  logic               fifo_full;
  logic               fifo_empty;

  spi_rx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .entry (push_entry),
    .pop   (pop),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign rx_valid     = ~fifo_empty;
  assign rx_data      = fifo_head[BYTE_W-1:0];
  assign rx_dc        = fifo_head[ENTRY_W-1];
  assign overflow_set = push && fifo_full && !pop;
`else
  localparam int unused_fifo_depth = FIFO_DEPTH;

  logic [ENTRY_W-1:0] out_q;
  logic               out_valid_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else if (push && (!out_valid_q || pop)) begin
      // A pop in the same cycle frees the register for the new byte.
      out_q       <= push_entry;
      out_valid_q <= 1'b1;
    end else if (pop) begin
      out_valid_q <= 1'b0;
    end
  end

  assign rx_valid     = out_valid_q;
  assign rx_data      = out_q[BYTE_W-1:0];
  assign rx_dc        = out_q[ENTRY_W-1];
  assign overflow_set = push && out_valid_q && !pop;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_q | overflow_set;
      frame_err_q <= frame_err_q | frame_err_set;
    end
  end

  assign overflow  = overflow_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_oled_rx.sv
// tb_spi_oled_rx
//   Directed bench for spi_oled_rx. Drives SPI mode 0 frames at an SCLK period
//   of 8 clk, records every accepted beat, and compares against hand-computed
//   expectations (both output-stage builds, selected by SPI_RX_FIFO_EN).
module tb_spi_oled_rx;

  localparam int CLK_HALF = 5;
`ifdef SPI_RX_FIFO_EN
  localparam int STAGE_SLOTS = 4;
`else
  localparam int STAGE_SLOTS = 1;
`endif

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic       clk = 1'b0;
  logic       reset;
  logic       spi_sclk;
  logic       spi_mosi;
  logic       spi_cs_n;
  logic       spi_dc;
  logic [7:0] rx_data;
  logic       rx_dc;
  logic       rx_valid;
  logic       rx_ready;
  logic       busy;
  logic       overflow;
  logic       frame_err;

  always #CLK_HALF clk = ~clk;

  spi_oled_rx #(
    .FIFO_DEPTH  (4),
    .SYNC_STAGES (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .spi_sclk  (spi_sclk),
    .spi_mosi  (spi_mosi),
    .spi_cs_n  (spi_cs_n),
    .spi_dc    (spi_dc),
    .rx_data   (rx_data),
    .rx_dc     (rx_dc),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .busy      (busy),
    .overflow  (overflow),
    .frame_err (frame_err)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard: beats accepted by the consumer vs expected queue
  // ---------------------------------------------------------------------------
  logic [8:0] exp_q[$];
  logic [8:0] got_q[$];
  int         rd_idx = 0;
  int         valid_cycles = 0;
  int         total = 0;
  int         bad = 0;

  always @(negedge clk) begin
    if (!reset) begin
      if (rx_valid) valid_cycles++;
      if (rx_valid && rx_ready) got_q.push_back({rx_dc, rx_data});
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic score(input string tag);
    logic [8:0]  e;
    logic [31:0] o;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      o = (rd_idx < got_q.size()) ? {23'd0, got_q[rd_idx]} : 32'hdead;
      check(tag, o, {23'd0, e});
      rd_idx++;
    end
    check({tag, "_count"}, got_q.size(), rd_idx);
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks (inputs change 2 ns after a rising clk edge)
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send_bits(input logic [7:0] data, input int n, input logic dc);
    for (int i = 0; i < n; i++) begin
      spi_mosi = data[7-i];
      spi_dc   = dc;
      repeat (4) tick();
      spi_sclk = 1'b1;
      repeat (4) tick();
      spi_sclk = 1'b0;
    end
  endtask

  task automatic frame_begin();
    spi_cs_n = 1'b0;
    repeat (4) tick();
  endtask

  task automatic frame_end();
    repeat (4) tick();
    spi_cs_n = 1'b1;
    repeat (6) tick();
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  int v0;

  initial begin
    reset    = 1'b1;
    spi_sclk = 1'b0;
    spi_mosi = 1'b0;
    spi_cs_n = 1'b1;
    spi_dc   = 1'b0;
    rx_ready = 1'b0;
    repeat (5) tick();
    check("rst_valid", rx_valid, 0);
    check("rst_data", rx_data, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;
    repeat (5) tick();

    // Single byte 0xA5, command
    rx_ready = 1'b1;
    v0 = valid_cycles;
    frame_begin();
    check("busy_in_frame", busy, 1);
    send_bits(8'hA5, 8, 1'b0);
    frame_end();
    exp_q.push_back({1'b0, 8'hA5});
    score("single_a5");
    check("a5_valid_cycles", valid_cycles - v0, 1);
    check("a5_overflow", overflow, 0);
    check("a5_frame_err", frame_err, 0);
    check("busy_after", busy, 0);

    // Burst of three with mixed D/C
    frame_begin();
    send_bits(8'h12, 8, 1'b1);
    send_bits(8'h34, 8, 1'b1);
    send_bits(8'h56, 8, 1'b0);
    frame_end();
    exp_q.push_back({1'b1, 8'h12});
    exp_q.push_back({1'b1, 8'h34});
    exp_q.push_back({1'b0, 8'h56});
    score("burst3");

    // Overflow: six bytes with consumer stalled
    rx_ready = 1'b0;
    frame_begin();
    for (int i = 1; i <= 6; i++) send_bits(8'(i), 8, 1'b1);
    frame_end();
    check("ovf_flag", overflow, 1);
    check("ovf_valid", rx_valid, 1);
    check("ovf_head", rx_data, 8'h01);
    rx_ready = 1'b1;
    repeat (10) tick();
    for (int i = 1; i <= STAGE_SLOTS; i++) exp_q.push_back({1'b1, 8'(i)});
    score("ovf_drain");
    check("ovf_sticky", overflow, 1);

    // Partial byte then a full frame
    frame_begin();
    send_bits(8'hFF, 5, 1'b0);
    frame_end();
    check("ferr_flag", frame_err, 1);
    frame_begin();
    send_bits(8'h3C, 8, 1'b0);
    frame_end();
    exp_q.push_back({1'b0, 8'h3C});
    score("after_ferr");

    // Reset mid-byte, CS held low across reset
    frame_begin();
    send_bits(8'hB7, 4, 1'b0);
    reset = 1'b1;
    repeat (2) tick();
    check("mid_rst_valid", rx_valid, 0);
    check("mid_rst_data", rx_data, 0);
    check("mid_rst_dc", rx_dc, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ovf", overflow, 0);
    check("mid_rst_ferr", frame_err, 0);
    reset = 1'b0;
    repeat (6) tick();
    send_bits(8'h99, 8, 1'b1);
    repeat (6) tick();
    score("no_capture_unarmed");
    spi_cs_n = 1'b1;
    repeat (6) tick();
    check("unarmed_ferr", frame_err, 0);
    frame_begin();
    send_bits(8'hF0, 8, 1'b1);
    frame_end();
    exp_q.push_back({1'b1, 8'hF0});
    score("post_rst_f0");
    check("post_rst_ovf", overflow, 0);
    check("post_rst_ferr", frame_err, 0);

    // Full stage, pop on the same cycle as the push from the 8th edge
    rx_ready = 1'b0;
    frame_begin();
    for (int i = 0; i < STAGE_SLOTS; i++) send_bits(8'h71 + 8'(i), 8, 1'b0);
    send_bits(8'h88, 7, 1'b1);
    spi_mosi = 1'b0;
    repeat (4) tick();
    spi_sclk = 1'b1;
    // Pad edge precedes clk edge k; synchronized edge is seen at k+1 and
    // the push lands on k+2, so ready is raised for that edge only.
    @(posedge clk);
    @(posedge clk);
    #2 rx_ready = 1'b1;
    @(posedge clk);
    #2 rx_ready = 1'b0;
    repeat (2) tick();
    spi_sclk = 1'b0;
    frame_end();
    check("same_cyc_ovf", overflow, 0);
    check("same_cyc_valid", rx_valid, 1);
    check("same_cyc_head", rx_data, (STAGE_SLOTS == 1) ? 8'h88 : 8'h72);
    exp_q.push_back({1'b0, 8'h71});
    score("same_cyc_pop");
    rx_ready = 1'b1;
    repeat (10) tick();
    for (int i = 1; i < STAGE_SLOTS; i++) exp_q.push_back({1'b0, 8'h71 + 8'(i)});
    exp_q.push_back({1'b1, 8'h88});
    score("same_cyc_drain");
    check("same_cyc_ovf_end", overflow, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
